// File: rtl/slink_gpio_serdes_align_ctrl.sv
// Word-alignment controller for the GPIO serdes RX path: finds the serdes_count phase on which
// TRAIN_PATTERN completes, confirms it over repeated words and publishes it as align_offset.
module slink_gpio_serdes_align_ctrl #(
  parameter int                        PAR_DATA_WIDTH  = 8,
  parameter int                        IO_DATA_WIDTH   = 1,
  parameter logic [PAR_DATA_WIDTH-1:0] TRAIN_PATTERN   = 8'hB8,
  parameter int                        LOCK_MATCHES    = 4,
  parameter int                        LOSS_MISMATCHES = 4,
  parameter int                        TIMEOUT_CYCLES  = 1024,
  localparam int                       DIV_RATIO       = PAR_DATA_WIDTH / IO_DATA_WIDTH,
  localparam int                       COUNT_W         = $clog2(DIV_RATIO)
) (
  input  logic                     serial_clk_gated,
  input  logic                     serial_reset,
  input  logic                     train_en,
  input  logic [COUNT_W-1:0]       serdes_count,
  input  logic [IO_DATA_WIDTH-1:0] rx_ser_data,
  output logic [COUNT_W-1:0]       align_offset,
  output logic                     align_locked,
  output logic                     align_error,
  output logic [2:0]               align_state,
  output logic                     match_pulse
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEARCH  = 3'd1;
  localparam logic [2:0] S_CONFIRM = 3'd2;
  localparam logic [2:0] S_LOCKED  = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
  localparam int MISS_W  = $clog2(LOSS_MISMATCHES + 1);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  // Counter values at which the next in-phase event completes the decision.
  localparam logic [MATCH_W-1:0] LOCK_LAST  = MATCH_W'(LOCK_MATCHES - 1);
  localparam logic [MISS_W-1:0]  LOSS_LAST  = MISS_W'(LOSS_MISMATCHES - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [PAR_DATA_WIDTH-1:0] r_window;
  logic [PAR_DATA_WIDTH-1:0] w_win_next;
  logic                      w_match;
  logic [2:0]                r_state;
  logic [COUNT_W-1:0]        r_cand_offset;
  logic [COUNT_W-1:0]        r_align_offset;
  logic [MATCH_W-1:0]        r_match_cnt;
  logic [MISS_W-1:0]         r_miss_cnt;
  logic [TIMER_W-1:0]        r_timer;
  logic                      r_match_pulse;

  // Newest beat enters at the top, so beat 0 of a completed word sits in the LSBs.
  assign w_win_next = {rx_ser_data, r_window[PAR_DATA_WIDTH-1:IO_DATA_WIDTH]};
  assign w_match    = (w_win_next == TRAIN_PATTERN);

  // NOTE: every register here uses an asynchronous reset so IDLE is forced the moment
  // serial_reset rises, even if the gated clock is stopped.
  always_ff @(posedge serial_clk_gated or posedge serial_reset) begin
    if (serial_reset) begin
      r_window      <= '0;
      r_match_pulse <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      r_window      <= w_win_next;
      r_match_pulse <= w_match;
    end
  end

  always_ff @(posedge serial_clk_gated or posedge serial_reset) begin
    if (serial_reset) begin
      r_state        <= S_IDLE;
      r_cand_offset  <= '0;
      r_align_offset <= '0;
      r_match_cnt    <= '0;
      r_miss_cnt     <= '0;
      r_timer        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (train_en) begin
            r_state <= S_SEARCH;
            r_timer <= '0;
          end
        end

        S_SEARCH, S_CONFIRM: begin
          if (!train_en) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
          end else if (r_timer == TIMER_LAST) begin
            r_state <= S_ERROR;
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
            if (r_state == S_SEARCH) begin
              if (w_match) begin
                r_cand_offset <= serdes_count;
                r_match_cnt   <= MATCH_W'(1);
                if (LOCK_MATCHES == 1) begin
                  r_state        <= S_LOCKED;
                  r_align_offset <= serdes_count;
                  r_miss_cnt     <= '0;
                end else begin
                  r_state <= S_CONFIRM;
                end
              end
            end else if (serdes_count == r_cand_offset) begin
              if (!w_match) begin
                r_state     <= S_SEARCH;
                r_match_cnt <= '0;
              end else if (r_match_cnt == LOCK_LAST) begin
                r_state        <= S_LOCKED;
                r_align_offset <= r_cand_offset;
                r_match_cnt    <= MATCH_W'(LOCK_MATCHES);
                r_miss_cnt     <= '0;
              end else begin
                r_match_cnt <= r_match_cnt + MATCH_W'(1);
              end
            end
          end
        end

        S_LOCKED: begin
          // Checking is suspended (miss count held) while training is disabled.
          if (train_en && serdes_count == r_align_offset) begin
            if (w_match) begin
              r_miss_cnt <= '0;
            end else if (r_miss_cnt == LOSS_LAST) begin
              r_state     <= S_SEARCH;
              r_timer     <= '0;
              r_miss_cnt  <= '0;
              r_match_cnt <= '0;
            end else begin
              r_miss_cnt <= r_miss_cnt + MISS_W'(1);
            end
          end
        end

        S_ERROR: begin
          if (!train_en) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign align_offset = r_align_offset;
  assign align_locked = (r_state == S_LOCKED);
  assign align_error  = (r_state == S_ERROR);
  assign align_state  = r_state;
  assign match_pulse  = r_match_pulse;

endmodule

// File: tb/tb_slink_gpio_serdes_align_ctrl.sv
// Directed bench for slink_gpio_serdes_align_ctrl at 8:1 with TRAIN_PATTERN 0xB8; the serdes
// counter is modelled so each word's last beat lands on count 3.
module tb_slink_gpio_serdes_align_ctrl;

  logic       serial_clk_gated = 1'b0;
  logic       serial_reset;
  logic       train_en;
  logic [2:0] serdes_count;
  logic [0:0] rx_ser_data;
  logic [2:0] align_offset;
  logic       align_locked;
  logic       align_error;
  logic [2:0] align_state;
  logic       match_pulse;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [2:0] cnt     = 3'd0;
  logic [7:0] pat     = 8'hB8;

  slink_gpio_serdes_align_ctrl dut (
    .serial_clk_gated (serial_clk_gated),
    .serial_reset     (serial_reset),
    .train_en         (train_en),
    .serdes_count     (serdes_count),
    .rx_ser_data      (rx_ser_data),
    .align_offset     (align_offset),
    .align_locked     (align_locked),
    .align_error      (align_error),
    .align_state      (align_state),
    .match_pulse      (match_pulse)
  );

  always #5 serial_clk_gated = ~serial_clk_gated;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one beat with the current counter value, then sample 1 time unit after the edge.
  task automatic beat(input logic b);
    rx_ser_data  = b;
    serdes_count = cnt;
    @(posedge serial_clk_gated);
    #1;
    cnt = cnt + 3'd1;
  endtask

  // One word, beat 0 first; starting at count 4 makes the word complete at count 3.
  task automatic word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) beat(w[i]);
  endtask

  task automatic do_reset();
    serial_reset = 1'b1;
    train_en     = 1'b0;
    repeat (2) beat(1'b0);
    serial_reset = 1'b0;
    cnt          = 3'd4;
  endtask

  initial begin
    serial_reset = 1'b1;
    train_en     = 1'b0;
    rx_ser_data  = 1'b0;
    serdes_count = 3'd0;

    // Reset held with random data and then with real training words.
    for (int i = 0; i < 8; i++) begin
      beat(1'($urandom_range(0, 1)));
      check("rst_state", align_state, 3'd0);
      check("rst_locked", align_locked, 1'b0);
      check("rst_error", align_error, 1'b0);
      check("rst_offset", align_offset, 3'd0);
      check("rst_pulse", match_pulse, 1'b0);
    end
    cnt = 3'd4;
    word(pat);
    check("rst_pulse_pat", match_pulse, 1'b0);
    check("rst_state_pat", align_state, 3'd0);
    serial_reset = 1'b0;
    cnt          = 3'd4;

    // Clean stream: first match at the end of word 1, lock 24 edges later.
    train_en = 1'b1;
    word(pat);
    check("t2_confirm", align_state, 3'd2);
    check("t2_pulse_w1", match_pulse, 1'b1);
    beat(pat[0]);
    check("t2_pulse_low", match_pulse, 1'b0);
    for (int i = 1; i < 8; i++) beat(pat[i]);
    check("t2_pulse_w2", match_pulse, 1'b1);
    check("t2_confirm_w2", align_state, 3'd2);
    word(pat);
    check("t2_confirm_w3", align_state, 3'd2);
    for (int i = 0; i < 7; i++) beat(pat[i]);
    check("t2_not_yet_locked", align_locked, 1'b0);
    beat(pat[7]);
    check("t2_locked", align_locked, 1'b1);
    check("t2_offset", align_offset, 3'd3);
    check("t2_state", align_state, 3'd3);

    // One corrupted beat in word 3 sends CONFIRM back to SEARCH; relock needs 4 more words.
    do_reset();
    train_en = 1'b1;
    word(pat);
    word(pat);
    check("t3_confirm", align_state, 3'd2);
    word(8'hBC);
    check("t3_fallback", align_state, 3'd1);
    word(pat);
    check("t3_reconfirm", align_state, 3'd2);
    word(pat);
    word(pat);
    check("t3_not_locked", align_locked, 1'b0);
    word(pat);
    check("t3_locked", align_locked, 1'b1);
    check("t3_offset", align_offset, 3'd3);

    // Loss of lock: 3 misses are tolerated, a good word clears them, 4 misses drop lock.
    repeat (3) word(8'h00);
    check("t5_3miss_locked", align_state, 3'd3);
    word(pat);
    check("t5_good_locked", align_state, 3'd3);
    repeat (3) word(8'h00);
    check("t5_3miss_again", align_state, 3'd3);
    word(8'h00);
    check("t5_lost_state", align_state, 3'd1);
    check("t5_lost_locked", align_locked, 1'b0);
    check("t5_lost_offset", align_offset, 3'd3);

    // Relock, then verify the miss count is held while train_en is low.
    repeat (4) word(pat);
    check("t6_relocked", align_locked, 1'b1);
    repeat (3) word(8'h00);
    check("t6_3miss", align_state, 3'd3);
    train_en = 1'b0;
    word(8'h5A);
    word(8'h00);
    check("t6_hold_state", align_state, 3'd3);
    check("t6_hold_locked", align_locked, 1'b1);
    train_en = 1'b1;
    word(8'h00);
    check("t6_held_miss_loss", align_state, 3'd1);
    word(pat);
    check("t6_confirm", align_state, 3'd2);
    beat(pat[0]);
    beat(pat[1]);
    #2;
    serial_reset = 1'b1;
    #1;
    check("t6_async_state", align_state, 3'd0);
    check("t6_async_offset", align_offset, 3'd0);
    check("t6_async_locked", align_locked, 1'b0);
    #2;
    serial_reset = 1'b0;
    train_en     = 1'b0;
    beat(1'b0);
    check("t6_idle_after", align_state, 3'd0);

    // Timeout: 1024 cycles in SEARCH with no match, then ERROR held until train_en drops.
    do_reset();
    train_en = 1'b1;
    repeat (1024) beat(1'b0);
    check("t4_still_search", align_state, 3'd1);
    check("t4_no_error_yet", align_error, 1'b0);
    beat(1'b0);
    check("t4_error_state", align_state, 3'd4);
    check("t4_error", align_error, 1'b1);
    repeat (3) beat(1'b0);
    check("t4_error_sticky", align_error, 1'b1);
    train_en = 1'b0;
    beat(1'b0);
    check("t4_idle", align_state, 3'd0);
    check("t4_error_clear", align_error, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
